// File: rtl/ws2812b_timing_calibrator.sv
// WS2812B receive-path auto-calibration: measures high-pulse widths and
// derives the bit threshold and idle gap for the decoder configuration.
module ws2812b_timing_calibrator #(
    parameter int SAMPLES       = 16,
    parameter int MIN_SPREAD    = 4,
    parameter int TIMEOUT       = 65535,
    parameter int DEF_THRESHOLD = 38,
    parameter int DEF_IDLE      = 3840
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    input  logic        start,
    input  logic        abort,
    output logic [15:0] threshold_cycles,
    output logic [15:0] idle_ticks,
    output logic        commit,
    output logic        busy,
    output logic        done,
    output logic [2:0]  error_code
);

    typedef enum logic [2:0] {
        IDLE, WAIT_LOW, WAIT_RISE, MEASURE, EVAL, COMMIT, FAIL
    } state_t;

    state_t      state, state_n;
    logic        din_q;
    logic [15:0] width, min_w, max_w, tmo;
    logic [7:0]  cnt;
    logic [2:0]  fail_code, code_n;

    logic        rise, tmo_hit, last, kill;
    logic [15:0] spread, thr, idl;
    logic [16:0] sum, sum1;
    logic [22:0] idle_full;

    assign rise      = din & ~din_q;
    assign tmo_hit   = ({1'b0, tmo} + 17'd1) == 17'(TIMEOUT);
    assign last      = ({1'b0, cnt} + 9'd1) == 9'(SAMPLES);
    assign kill      = abort && (state != IDLE);
    assign spread    = max_w - min_w;
    assign sum       = {1'b0, min_w} + {1'b0, max_w};
    assign sum1      = sum + 17'd1;
    assign thr       = sum1[16:1];
    assign idle_full = 23'(sum) * 23'd48;
    // Gaps beyond the 16-bit range pin to the largest programmable value
    assign idl       = (|idle_full[22:16]) ? 16'hFFFF : idle_full[15:0];

    assign commit = (state == COMMIT) && !abort;
    assign busy   = (state != IDLE);

    always_comb begin
        state_n = state;
        code_n  = 3'd0;
        unique case (state)
            IDLE:      if (start && !abort) state_n = WAIT_LOW;
            WAIT_LOW: begin
                if (tmo_hit) begin
                    state_n = FAIL;
                    code_n  = 3'd1;
                end else if (!din) begin
                    state_n = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (rise) begin
                    state_n = MEASURE;
                end else if (tmo_hit) begin
                    state_n = FAIL;
                    code_n  = 3'd1;
                end
            end
            MEASURE: begin
                if (din) begin
                    if (width == 16'hFFFF) begin
                        state_n = FAIL;
                        code_n  = 3'd2;
                    end
                end else begin
                    state_n = last ? EVAL : WAIT_RISE;
                end
            end
            EVAL: begin
                if (spread < 16'(MIN_SPREAD)) begin
                    state_n = FAIL;
                    code_n  = 3'd3;
                end else begin
                    state_n = COMMIT;
                end
            end
            COMMIT:    state_n = IDLE;
            FAIL:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
        if (kill) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q            <= 1'b0;
            width            <= '0;
            min_w            <= 16'hFFFF;
            max_w            <= '0;
            cnt              <= '0;
            tmo              <= '0;
            fail_code        <= '0;
            threshold_cycles <= 16'(DEF_THRESHOLD);
            idle_ticks       <= 16'(DEF_IDLE);
            done             <= 1'b0;
            error_code       <= '0;
        end else begin
            din_q <= din;
            if (state_n == FAIL) fail_code <= code_n;
            if (kill) begin
                error_code <= 3'd4;
                done       <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            min_w      <= 16'hFFFF;
                            max_w      <= '0;
                            cnt        <= '0;
                            tmo        <= '0;
                            done       <= 1'b0;
                            error_code <= '0;
                        end
                    end
                    WAIT_LOW:  tmo <= tmo + 16'd1;
                    WAIT_RISE: begin
                        if (rise) begin
                            width <= 16'd1;
                            tmo   <= '0;
                        end else begin
                            tmo <= tmo + 16'd1;
                        end
                    end
                    MEASURE: begin
                        if (din) begin
                            if (width != 16'hFFFF) width <= width + 16'd1;
                        end else begin
                            if (width < min_w) min_w <= width;
                            if (width > max_w) max_w <= width;
                            cnt <= cnt + 8'd1;
                            tmo <= '0;
                        end
                    end
                    COMMIT: begin
                        threshold_cycles <= thr;
                        idle_ticks       <= idl;
                        done             <= 1'b1;
                    end
                    FAIL: begin
                        done       <= 1'b1;
                        error_code <= fail_code;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ws2812b_timing_calibrator.sv
// Directed bench for ws2812b_timing_calibrator: calibration results,
// failure codes, abort and asynchronous reset.
module tb_ws2812b_timing_calibrator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din;
    logic        start;
    logic        abort;
    logic [15:0] threshold_cycles;
    logic [15:0] idle_ticks;
    logic        commit;
    logic        busy;
    logic        done;
    logic [2:0]  error_code;

    int n_tests = 0;
    int n_fail  = 0;
    int n_commit = 0;
    int c0;
    int k;

    ws2812b_timing_calibrator #(.TIMEOUT(100)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .din              (din),
        .start            (start),
        .abort            (abort),
        .threshold_cycles (threshold_cycles),
        .idle_ticks       (idle_ticks),
        .commit           (commit),
        .busy             (busy),
        .done             (done),
        .error_code       (error_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && commit) n_commit++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic pulse(input int hi, input int lo);
        din = 1'b1;
        repeat (hi) tick;
        din = 1'b0;
        repeat (lo) tick;
    endtask

    task automatic wait_done(input string tag, input int max);
        int i = 0;
        while (!done && i < max) begin
            tick;
            i++;
        end
        check({tag, "_done"}, 32'(done), 1);
    endtask

    task automatic check_out(input string tag, input int thr, input int idl,
                             input int err);
        check({tag, "_thr"}, 32'(threshold_cycles), 32'(thr));
        check({tag, "_idle"}, 32'(idle_ticks), 32'(idl));
        check({tag, "_err"}, 32'(error_code), 32'(err));
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        din   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_out("rst", 38, 3840, 0);
        check("rst_done", 32'(done), 0);
        check("rst_commit", 32'(commit), 0);
        rst_n = 1'b1;
        tick;

        // equal widths: spread too small
        c0 = n_commit;
        do_start;
        check("t2_busy", 32'(busy), 1);
        tick;
        for (int i = 0; i < 16; i++) pulse(26, 30);
        wait_done("t2", 20);
        check_out("t2", 38, 3840, 3);
        check("t2_commits", 32'(n_commit - c0), 0);

        // start with abort in IDLE does nothing
        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        tick;
        check_out("sa", 38, 3840, 3);
        check("sa_done", 32'(done), 1);

        // 26/51 alternating
        c0 = n_commit;
        do_start;
        check("t1_clr", 32'(done), 0);
        tick;
        for (int i = 0; i < 16; i++) pulse((i % 2 == 1) ? 51 : 26, 30);
        wait_done("t1", 20);
        check_out("t1", 39, 3696, 0);
        check("t1_commits", 32'(n_commit - c0), 1);

        // din held low: timeout
        c0 = n_commit;
        din = 1'b0;
        do_start;
        k = 0;
        while (!done && k < 300) begin
            tick;
            k++;
        end
        check("tmo_lat", 32'(k >= 100 && k <= 102), 1);
        check_out("tmo", 39, 3696, 1);
        check("tmo_commits", 32'(n_commit - c0), 0);

        // partial pulse at start is discarded
        c0 = n_commit;
        din = 1'b1;
        do_start;
        repeat (9) tick;
        din = 1'b0;
        repeat (5) tick;
        for (int i = 0; i < 16; i++) pulse((i % 2 == 1) ? 40 : 20, 30);
        wait_done("t4", 20);
        check_out("t4", 30, 2880, 0);
        check("t4_commits", 32'(n_commit - c0), 1);

        // long pulses saturate idle_ticks
        c0 = n_commit;
        do_start;
        tick;
        for (int i = 0; i < 16; i++) pulse((i % 2 == 1) ? 1400 : 700, 30);
        wait_done("t5", 20);
        check_out("t5", 1050, 16'hFFFF, 0);
        check("t5_commits", 32'(n_commit - c0), 1);

        // abort mid-measurement keeps previous calibration
        c0 = n_commit;
        do_start;
        tick;
        pulse(700, 30);
        pulse(1400, 30);
        din = 1'b1;
        repeat (100) tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        din = 1'b0;
        check_out("ab", 1050, 16'hFFFF, 4);
        check("ab_done", 32'(done), 1);
        repeat (3) tick;
        check("ab_commits", 32'(n_commit - c0), 0);

        // async reset during MEASURE
        c0 = n_commit;
        do_start;
        tick;
        pulse(20, 30);
        pulse(40, 30);
        din = 1'b1;
        repeat (5) tick;
        check("rm_busy0", 32'(busy), 1);
        rst_n = 1'b0;
        #2;
        check_out("rm", 38, 3840, 0);
        check("rm_done", 32'(done), 0);
        check("rm_commit", 32'(commit), 0);
        din = 1'b0;
        tick;
        rst_n = 1'b1;
        repeat (3) tick;
        check("rm_commits", 32'(n_commit - c0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
